// File: rtl/riscv_pkg.sv
// Shared types and constants for the multi-core memory arbiter slice.
package riscv_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int NUM_CORES_DEF = 8;
  localparam int BE_WIDTH      = 8;

endpackage : riscv_pkg

// File: rtl/shared_sram.sv
// Single-port-style backing store: byte-enabled synchronous write, registered read.
module shared_sram
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MEM_SIZE   = 1024,
  parameter int AW         = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [BE_WIDTH-1:0]   wbe,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [MEM_SIZE];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Byte-lane write; the array itself is deliberately never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (wbe[b]) begin
          mem_r[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule : shared_sram

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting NUM_CORES requesters one access at a time into a
// shared SRAM; two-cycle grant-to-response with out-of-range fault reporting.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int NUM_CORES  = NUM_CORES_DEF,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int MEM_SIZE   = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CORES-1:0]             req_i,
  input  logic [NUM_CORES-1:0]             we_i,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]  wdata_i,
  input  logic [NUM_CORES*BE_WIDTH-1:0]    be_i,
  output logic [NUM_CORES-1:0]             gnt_o,
  output logic [NUM_CORES-1:0]             rvalid_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic                             err_o,
  output logic                             busy_o
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int AW    = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  typedef logic [ADDR_WIDTH-4:0] widx_t;
  localparam widx_t MEM_LIMIT = widx_t'(MEM_SIZE);
  localparam logic [NUM_CORES-1:0] ONE_HOT_LSB = {{(NUM_CORES-1){1'b0}}, 1'b1};

  arb_state_t            state_r;
  logic [IDX_W-1:0]      last_grant_r;
  logic [7:0]            grant_cnt_r;
  logic [IDX_W-1:0]      cap_idx_r;
  logic                  cap_we_r;
  widx_t                 cap_widx_r;
  logic [DATA_WIDTH-1:0] cap_wdata_r;
  logic [BE_WIDTH-1:0]   cap_be_r;

  logic [IDX_W-1:0]      win_s;
  logic                  any_req_s;
  logic                  sel_we_s;
  widx_t                 sel_widx_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic [BE_WIDTH-1:0]   sel_be_s;
  logic                  cap_err_s;
  logic                  sram_we_s;
  logic                  sram_re_s;
  logic [DATA_WIDTH-1:0] sram_q_s;
  logic                  unused_s;

  // Round-robin pick: scan from lowest to highest priority so the highest-priority
  // requester (first after last_grant) is the final assignment.
  always_comb begin
    win_s = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      win_s = req_i[(int'(last_grant_r) + i + 32'sd1) % NUM_CORES]
            ? IDX_W'((int'(last_grant_r) + i + 32'sd1) % NUM_CORES)
            : win_s;
    end
  end

  // Byte-offset bits are irrelevant to word accesses.
  always_comb begin
    unused_s = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      unused_s = unused_s ^ (^addr_i[k*ADDR_WIDTH +: 3]);
    end
  end

  assign any_req_s   = |req_i;
  assign sel_we_s    = we_i[win_s];
  assign sel_widx_s  = addr_i[int'(win_s)*ADDR_WIDTH + 3 +: ADDR_WIDTH-3];
  assign sel_wdata_s = wdata_i[int'(win_s)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_be_s    = be_i[int'(win_s)*BE_WIDTH +: BE_WIDTH];

  assign cap_err_s = (cap_widx_r >= MEM_LIMIT);
  assign sram_we_s = (state_r == BUSY) && cap_we_r && !cap_err_s;
  // Read launches at grant so the word is ready for the BUSY-cycle response.
  assign sram_re_s = (state_r == IDLE) && any_req_s;

  shared_sram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_SIZE   (MEM_SIZE),
    .AW         (AW)
  ) u_sram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (sram_we_s),
    .waddr (cap_widx_r[AW-1:0]),
    .wdata (cap_wdata_r),
    .wbe   (cap_be_r),
    .re    (sram_re_s),
    .raddr (sel_widx_s[AW-1:0]),
    .rdata (sram_q_s)
  );

  // Arbitration FSM with capture and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= IDX_W'(NUM_CORES - 1);
      grant_cnt_r  <= 8'd0;
      cap_idx_r    <= '0;
      cap_we_r     <= 1'b0;
      cap_widx_r   <= '0;
      cap_wdata_r  <= '0;
      cap_be_r     <= '0;
      gnt_o        <= '0;
      rvalid_o     <= '0;
      rdata_o      <= '0;
      err_o        <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rvalid_o <= '0;
          rdata_o  <= '0;
          err_o    <= 1'b0;
          if (any_req_s) begin
            gnt_o       <= ONE_HOT_LSB << win_s;
            cap_idx_r   <= win_s;
            cap_we_r    <= sel_we_s;
            cap_widx_r  <= sel_widx_s;
            cap_wdata_r <= sel_wdata_s;
            cap_be_r    <= sel_be_s;
            grant_cnt_r <= grant_cnt_r + 8'd1;
            busy_o      <= 1'b1;
            state_r     <= BUSY;
          end else begin
            gnt_o <= '0;
          end
        end
        BUSY: begin
          gnt_o        <= '0;
          rvalid_o     <= ONE_HOT_LSB << cap_idx_r;
          rdata_o      <= (cap_we_r || cap_err_s) ? '0 : sram_q_s;
          err_o        <= cap_err_s;
          last_grant_r <= cap_idx_r;
          busy_o       <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          gnt_o    <= '0;
          rvalid_o <= '0;
          rdata_o  <= '0;
          err_o    <= 1'b0;
          busy_o   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule : mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_CORES, default 8: number of requesting cores; index width is 3 bits, matching core_id.
REQ-002 Parameter DATA_WIDTH, default 64: data word width.
REQ-003 Parameter ADDR_WIDTH, default 64: byte-address width.
REQ-004 Parameter MEM_SIZE, default 1024: backing store depth in DATA_WIDTH words.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 req_i  in  NUM_CORES  per-core request level; held until that core's rvalid_o.
REQ-008 we_i  in  NUM_CORES  per-core write-enable (1 = store).
REQ-009 addr_i  in  NUM_CORES*ADDR_WIDTH  per-core byte address; slice k belongs to core k.
REQ-010 wdata_i  in  NUM_CORES*DATA_WIDTH  per-core store data.
REQ-011 be_i  in  NUM_CORES*8  per-core byte enables.
REQ-012 gnt_o  out  NUM_CORES  one-hot grant; one-cycle pulse.
REQ-013 rvalid_o  out  NUM_CORES  one-hot response valid; one-cycle pulse.
REQ-014 rdata_o  out  DATA_WIDTH  load data, shared by all cores; valid only with rvalid_o.
REQ-015 err_o  out  1  access fault; valid only with rvalid_o.
REQ-016 busy_o  out  1  high while in state BUSY.

Function
REQ-017 FSM states: IDLE and BUSY.
REQ-018 IDLE with any req_i bit set: select the winner round-robin, starting at index (last_grant+1) mod NUM_CORES; pulse gnt_o[winner]; capture the winner's index, we, addr, wdata and be; go to BUSY.
REQ-019 BUSY: perform the access on the captured request; pulse rvalid_o[winner] and drive rdata_o/err_o; set last_grant to the winner; return to IDLE.
REQ-020 Each access is 2 cycles from grant to response; peak throughput is one access per 2 cycles.
REQ-021 Word index is addr[ADDR_WIDTH-1:3].
REQ-022 An index >= MEM_SIZE sets err_o=1 and rdata_o=0, and no write occurs.
REQ-023 An error-free store writes only the bytes whose be bit is set; rdata_o=0 on a store response.
REQ-024 An error-free load returns the full stored word; be is ignored; the core performs extraction and sign extension.
REQ-025 A store with be=0 is a legal no-op and returns err_o=0.
REQ-026 Requests that arrive while in BUSY are not sampled until the next IDLE cycle.
REQ-027 A request dropped before grant is not served; no obligation exists once it is dropped.
REQ-028 When several cores request simultaneously, each is served within NUM_CORES grants (no starvation).
REQ-029 An 8-bit counter grant_cnt increments per grant and wraps from 255 to 0 (debug only, not an output).

Reset
REQ-030 Asynchronous reset: state=IDLE, last_grant=NUM_CORES-1 (so core 0 wins first), grant_cnt=0, all captured registers=0.
REQ-031 During and after reset: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, busy_o=0.
REQ-032 Reset mid-access aborts the access: no write commits and no rvalid is issued; memory contents are not cleared.

Structure
REQ-033 Package riscv_pkg holds arb_state_t (IDLE, BUSY), NUM_CORES_DEF=8 and BE_WIDTH=8.
REQ-034 Sub-module shared_sram: MEM_SIZE x DATA_WIDTH array with synchronous byte-enabled write and registered read.
REQ-035 mem_arbiter contains only arbitration, capture, FSM and response muxing.

Verification
REQ-036 Single load: after reset, core 0 loads addr 0x10 holding 0xDEADBEEF_CAFEF00D -> gnt_o=0x01, and the next cycle rvalid_o=0x01 with that data and err_o=0.
REQ-037 Byte store: core 3 stores 0xFF..FF to addr 0x8 with be=0x0F over 0 -> a reload returns 0x00000000_FFFFFFFF.
REQ-038 Fairness: all 8 cores request continuously from reset -> grant order is 0,1,...,7,0; each core's gnt pulses exactly every 16 cycles.
REQ-039 Out of range: core 5 loads byte address 1024*8 -> err_o=1, rdata_o=0; a store to the same address leaves memory unchanged.
REQ-040 Reset in BUSY: assert rst_n=0 during the cycle after a store grant -> the target word is unchanged, no rvalid, and core 0 is granted first after release.
REQ-041 Simultaneous with priority: last_grant=2 and cores 1 and 6 request -> core 6 is granted, then core 1.
